// File: rtl/avalon_ram_if.sv
// Avalon-MM bus bundle between a master and the avalon_ram_pipelined slave.
// Handshake: a request is taken on a rising edge where chipselect & (read|write) & ~waitrequest.
interface avalon_ram_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W/8-1:0]   byteenable;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output chipselect, read, write, address, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  chipselect, read, write, address, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avalon_ram_pipelined.sv
// Single-port byte-lane RAM behind an Avalon-MM slave with 1/2-cycle read latency and zero sweep.
// Optional macro RAM_OOR_COUNT_EN enables the saturating out-of-range access counter.
module avalon_ram_pipelined #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 16,
    parameter int DEPTH          = 64000,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reset_req,
    input  logic               clken,
    avalon_ram_if.slave        bus,
    output logic               init_done,
    output logic [15:0]        oor_count,
    output logic               dbg_state
);
    localparam int              NB       = DATA_W / 8;
    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    sweep_q, sweep_d;
    logic                init_done_q, init_done_d;
    logic                rdv_q, rdv_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                en, wait_w, acc, wr_acc, rd_acc, in_range;
    logic [IDX_W-1:0]    addr_idx;
    logic [DATA_W-1:0]   rd_word;
    logic                mem_we;
    logic [IDX_W-1:0]    mem_widx;
    logic [NB-1:0]       mem_be;
    logic [DATA_W-1:0]   mem_wdata;

    assign en       = clken & ~reset_req;
    assign wait_w   = (state_q != ST_RUN) | ~en;
    assign acc      = bus.chipselect & (bus.read | bus.write) & ~wait_w;
    assign wr_acc   = acc & bus.write;
    assign rd_acc   = acc & bus.read & ~bus.write;
    assign in_range = {1'b0, bus.address} < DEPTH_A;
    assign addr_idx = bus.address[IDX_W-1:0];
    // Out-of-range reads return zero but still travel through the normal pipeline.
    assign rd_word  = in_range ? mem[addr_idx] : '0;

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        mem_we    = 1'b0;
        mem_widx  = addr_idx;
        mem_be    = bus.byteenable;
        mem_wdata = bus.writedata;
        if (state_q == ST_INIT) begin
            if (en) begin
                if (CLEAR_ON_RESET != 0) begin
                    mem_we    = 1'b1;
                    mem_widx  = sweep_q;
                    mem_be    = '1;
                    mem_wdata = '0;
                    if (sweep_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
        end else if (wr_acc && in_range) begin
            mem_we = 1'b1;
        end
        init_done_d = (state_d == ST_RUN);
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              s1_v_q, s1_v_d;
            logic [DATA_W-1:0] s1_d_q, s1_d_d;

            // The middle stage only advances on enabled cycles so stalls never drop or repeat a result.
            always_comb begin
                s1_v_d  = en ? rd_acc : s1_v_q;
                s1_d_d  = rd_acc ? rd_word : s1_d_q;
                rdv_d   = en & s1_v_q;
                rdata_d = (en && s1_v_q) ? s1_d_q : rdata_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_v_q <= 1'b0;
                    s1_d_q <= '0;
                end else begin
                    s1_v_q <= s1_v_d;
                    s1_d_q <= s1_d_d;
                end
            end
        end else begin : g_lat1
            always_comb begin
                rdv_d   = rd_acc;
                rdata_d = rd_acc ? rd_word : rdata_q;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
            rdv_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            init_done_q <= init_done_d;
            rdv_q       <= rdv_d;
            rdata_q     <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) mem[mem_widx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
    end

`ifdef RAM_OOR_COUNT_EN
    logic [15:0] oor_q, oor_d;

    always_comb begin
        oor_d = oor_q;
        if (acc && !in_range && (oor_q != 16'hFFFF)) oor_d = oor_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) oor_q <= '0;
        else       oor_q <= oor_d;
    end

    assign oor_count = oor_q;
`else
    assign oor_count = '0;
`endif

    assign bus.readdata      = rdata_q;
    assign bus.readdatavalid = rdv_q;
    assign bus.waitrequest   = wait_w;
    assign init_done         = init_done_q;
    assign dbg_state         = (state_q == ST_RUN);
endmodule

// File: tb/tb_avalon_ram_pipelined.sv
// Bench for avalon_ram_pipelined: latency-1 and latency-2 instances on shared stimulus,
// checked every cycle against a memory/accept-list model plus directed literal expectations.
module tb_avalon_ram_pipelined;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0, reset = 1'b1, reset_req = 1'b0, clken = 1'b1;
  logic m_cs = 1'b0, m_read = 1'b0, m_write = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [3:0] m_be = '0;
  logic [DW-1:0] m_wdata = '0;

  avalon_ram_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  avalon_ram_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

  assign if0.chipselect = m_cs;    assign if1.chipselect = m_cs;
  assign if0.read       = m_read;  assign if1.read       = m_read;
  assign if0.write      = m_write; assign if1.write      = m_write;
  assign if0.address    = m_addr;  assign if1.address    = m_addr;
  assign if0.byteenable = m_be;    assign if1.byteenable = m_be;
  assign if0.writedata  = m_wdata; assign if1.writedata  = m_wdata;

  logic init0, init1, st0, st1;
  logic [15:0] oor0, oor1;

  avalon_ram_pipelined #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .bus(if0),
    .init_done(init0), .oor_count(oor0), .dbg_state(st0));

  avalon_ram_pipelined #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .bus(if1),
    .init_done(init1), .oor_count(oor1), .dbg_state(st1));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_q[$];
  int stamp_q[$];
  int rd_ptr[2];
  logic [DW-1:0] last_d[2];
  int en_cnt;
  logic [15:0] oor_m;
  logic run_m, wait_m, acc_m;

  function automatic logic [15:0] oor_expect();
`ifdef RAM_OOR_COUNT_EN
    return oor_m;
`else
    return 16'd0;
`endif
  endfunction

  // A read accepted before enabled edge number s is due once lat enabled edges have passed.
  task automatic mon_inst(input int i, input int lat, input logic rdv, input logic [DW-1:0] rdd);
    if (rd_ptr[i] < exp_q.size() && (en_cnt - stamp_q[rd_ptr[i]]) >= lat) begin
      check($sformatf("rdv%0d", i), rdv, 1);
      check($sformatf("rdata%0d", i), rdd, exp_q[rd_ptr[i]]);
      last_d[i] = exp_q[rd_ptr[i]];
      rd_ptr[i]++;
    end else begin
      check($sformatf("rdv_idle%0d", i), rdv, 0);
      check($sformatf("rdata_hold%0d", i), rdd, last_d[i]);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("rst_rdv0", if0.readdatavalid, 0);   check("rst_rdv1", if1.readdatavalid, 0);
      check("rst_rdata0", if0.readdata, 0);      check("rst_rdata1", if1.readdata, 0);
      check("rst_wait0", if0.waitrequest, 1);    check("rst_wait1", if1.waitrequest, 1);
      check("rst_init0", init0, 0);              check("rst_init1", init1, 0);
      check("rst_oor0", oor0, 0);                check("rst_oor1", oor1, 0);
      for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
      exp_q.delete();
      stamp_q.delete();
      rd_ptr = '{0, 0};
      last_d = '{32'd0, 32'd0};
      en_cnt = 0;
      oor_m = '0;
    end else begin
      run_m  = (en_cnt >= DEPTH);
      wait_m = !run_m || !clken || reset_req;
      check("wait0", if0.waitrequest, wait_m);   check("wait1", if1.waitrequest, wait_m);
      check("init0", init0, run_m);              check("init1", init1, run_m);
      check("state0", st0, run_m);               check("state1", st1, run_m);
      check("oor0", oor0, oor_expect());         check("oor1", oor1, oor_expect());
      mon_inst(0, 1, if0.readdatavalid, if0.readdata);
      mon_inst(1, 2, if1.readdatavalid, if1.readdata);
      acc_m = m_cs && (m_read || m_write) && !wait_m;
      if (acc_m) begin
        if (int'(m_addr) >= DEPTH) begin
          if (oor_m != 16'hFFFF) oor_m = oor_m + 16'd1;
        end else if (m_write) begin
          for (int l = 0; l < 4; l++)
            if (m_be[l]) mem_m[int'(m_addr)][l*8 +: 8] = m_wdata[l*8 +: 8];
        end
        if (m_read && !m_write) begin
          exp_q.push_back((int'(m_addr) < DEPTH) ? mem_m[int'(m_addr)] : '0);
          stamp_q.push_back(en_cnt);
        end
      end
      if (clken && !reset_req) en_cnt++;
    end
  end

  // Result log of the latency-2 instance for directed checks.
  logic [DW-1:0] log_d[$];
  int log_c[$];
  always @(negedge clk) begin
    if (!reset && if1.readdatavalid) begin
      log_d.push_back(if1.readdata);
      log_c.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  int acc_cyc;

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] b);
    int n;
    logic got;
    m_cs = 1'b1; m_read = r; m_write = w; m_addr = a; m_wdata = d; m_be = b;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = !if0.waitrequest;
      if (got) acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) check("accept_timeout", got, 1);
    m_cs = 1'b0; m_read = 1'b0; m_write = 1'b0;
  endtask

  task automatic count_sweep(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!if0.waitrequest) break;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  int n_sw, ac;

  initial begin
    reset = 1'b1;
    wait_cycles(3);
    check("hold_rst_wait", if1.waitrequest, 1);
    reset = 1'b0;
    count_sweep(n_sw);
    check("sweep_len", n_sw, 16);
    check("init_after_sweep", init1, 1);

    for (int a = 0; a < DEPTH; a++) bus_op(1'b1, 1'b0, AW'(a), '0, '0);
    wait_cycles(4);

    bus_op(1'b0, 1'b1, 8'd5, 32'hDEADBEEF, 4'b1111);
    bus_op(1'b0, 1'b1, 8'd5, 32'h00001200, 4'b0010);
    log_d.delete(); log_c.delete();
    bus_op(1'b1, 1'b0, 8'd5, '0, '0);
    ac = acc_cyc;
    wait_cycles(4);
    check("be_merge_cnt", log_d.size(), 1);
    if (log_d.size() > 0) begin
      check("be_merge_data", log_d[0], 32'hDEAD12EF);
      check("lat2_timing", log_c[0] - ac, 2);
    end

    for (int a = 0; a < 4; a++) bus_op(1'b0, 1'b1, AW'(a), 32'h10 + a, 4'hF);
    log_d.delete(); log_c.delete();
    bus_op(1'b1, 1'b0, 8'd0, '0, '0);
    bus_op(1'b1, 1'b0, 8'd1, '0, '0);
    clken = 1'b0;
    wait_cycles(3);
    clken = 1'b1;
    bus_op(1'b1, 1'b0, 8'd2, '0, '0);
    bus_op(1'b1, 1'b0, 8'd3, '0, '0);
    wait_cycles(5);
    check("stall_cnt", log_d.size(), 4);
    if (log_d.size() == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("stall_data%0d", i), log_d[i], 32'h10 + i);
      check("stall_gap", log_c[1] - log_c[0], 4);
      check("stall_b2b_a", log_c[2] - log_c[1], 1);
      check("stall_b2b_b", log_c[3] - log_c[2], 1);
    end

    log_d.delete(); log_c.delete();
    bus_op(1'b1, 1'b1, 8'd3, 32'hA5A5A5A5, 4'hF);
    wait_cycles(4);
    check("rw_no_valid", log_d.size(), 0);
    bus_op(1'b1, 1'b0, 8'd3, '0, '0);
    wait_cycles(4);
    check("rw_read_cnt", log_d.size(), 1);
    if (log_d.size() > 0) check("rw_read_data", log_d[0], 32'hA5A5A5A5);

    log_d.delete(); log_c.delete();
    bus_op(1'b1, 1'b0, 8'd0, '0, '0);
    ac = acc_cyc;
    reset_req = 1'b1;
    wait_cycles(2);
    reset_req = 1'b0;
    wait_cycles(4);
    check("rreq_cnt", log_d.size(), 1);
    if (log_d.size() > 0) begin
      check("rreq_data", log_d[0], 32'h10);
      check("rreq_timing", log_c[0] - ac, 4);
    end

    log_d.delete(); log_c.delete();
    bus_op(1'b0, 1'b1, 8'd20, 32'hFFFFFFFF, 4'hF);
    bus_op(1'b1, 1'b0, 8'd20, '0, '0);
    wait_cycles(4);
    check("oor_read_cnt", log_d.size(), 1);
    if (log_d.size() > 0) check("oor_read_data", log_d[0], 32'h0);
    for (int a = 0; a < DEPTH; a++) bus_op(1'b1, 1'b0, AW'(a), '0, '0);
    wait_cycles(4);
`ifdef RAM_OOR_COUNT_EN
    check("oor_count_lit", oor1, 2);
`else
    check("oor_count_lit", oor1, 0);
`endif

    log_d.delete(); log_c.delete();
    bus_op(1'b0, 1'b1, 8'd9, 32'h12345678, 4'hF);
    bus_op(1'b1, 1'b0, 8'd9, '0, '0);
    wait_cycles(4);
    check("raw_cnt", log_d.size(), 1);
    if (log_d.size() > 0) check("raw_data", log_d[0], 32'h12345678);

    reset = 1'b1;
    #1;
    check("async_rdata", if1.readdata, 0);
    check("async_init", init1, 0);
    check("async_wait", if1.waitrequest, 1);
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(7);
    reset = 1'b1;
    #1;
    check("midsweep_wait", if0.waitrequest, 1);
    check("midsweep_init", init0, 0);
    wait_cycles(1);
    reset = 1'b0;
    count_sweep(n_sw);
    check("resweep_len", n_sw, 16);

    log_d.delete(); log_c.delete();
    bus_op(1'b1, 1'b0, 8'd5, '0, '0);
    wait_cycles(4);
    check("cleared_cnt", log_d.size(), 1);
    if (log_d.size() > 0) check("cleared_data", log_d[0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: got time %0t, expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
